// File: rtl/cpu_types_pkg.sv
// Shared core types and constants.
//   word_t           : 32-bit machine word
//   PC_RESET_DEFAULT : default fetch PC after reset
//   PC_INC_DEFAULT   : default sequential fetch increment in bytes
//   pcsel_t          : next-PC source select, in descending priority order
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam word_t PC_RESET_DEFAULT = 32'h0000_0000;
   localparam int    PC_INC_DEFAULT   = 4;

   typedef enum logic [2:0] {
      PCSEL_RST,
      PCSEL_EX,
      PCSEL_HOLD,
      PCSEL_ID,
      PCSEL_RAS,
      PCSEL_INC
   } pcsel_t;

endpackage

// File: rtl/pc_seq_if.sv
// Bundle of the pc_sequencer signals.
//   pcseq modport : sequencer view (control/targets in, PC and RAS status out)
//   tb modport    : driver view (the reverse)
// With PC_ALIGN_CHK_EN defined the bundle also carries misalign.
interface pc_seq_if #(
   parameter int WORD_W = 32
) (
   input logic clk
);
   logic              rst;
   logic              pcenable;
   logic              ex_redirect;
   logic [WORD_W-1:0] ex_target;
   logic              id_redirect;
   logic [WORD_W-1:0] id_target;
   logic              call_push;
   logic [WORD_W-1:0] push_addr;
   logic              ret_pop;
   logic [WORD_W-1:0] pcout;
   logic              pred_valid;
   logic              ras_empty;
   logic              ras_full;
`ifdef PC_ALIGN_CHK_EN
   logic              misalign;
`endif

   modport pcseq (
      input  clk, rst, pcenable, ex_redirect, ex_target, id_redirect, id_target,
             call_push, push_addr, ret_pop,
`ifdef PC_ALIGN_CHK_EN
      output misalign,
`endif
      output pcout, pred_valid, ras_empty, ras_full
   );

   modport tb (
      input  clk, pcout, pred_valid, ras_empty, ras_full,
`ifdef PC_ALIGN_CHK_EN
      input  misalign,
`endif
      output rst, pcenable, ex_redirect, ex_target, id_redirect, id_target,
             call_push, push_addr, ret_pop
   );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and an entry count.
//   clk, rst        : clock, synchronous active-high reset (clears count only)
//   push, push_data : push a return address; when full the oldest entry is overwritten
//   pop             : drop the top entry; ignored when empty
//   push+pop        : top entry is replaced, count unchanged
//   top             : current top entry
//   empty, full     : count == 0 / count == DEPTH
module pc_ras #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [WORD_W-1:0] push_data,
   output logic [WORD_W-1:0] top,
   output logic              empty,
   output logic              full
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  top_ptr;
   logic [PTR_W-1:0]  top_inc;
   logic [CNT_W-1:0]  count;
   logic              do_pop;

   assign top_inc = top_ptr + 1'b1;
   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign top     = mem[top_ptr];
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         top_ptr <= '0;
         count   <= '0;
      end else if (push && do_pop) begin
         // pop-then-push collapses to an in-place overwrite of the top
      end else if (push) begin
         top_ptr <= top_inc;
         if (!full)
            count <= count + 1'b1;
      end else if (do_pop) begin
         top_ptr <= top_ptr - 1'b1;
         count   <= count - 1'b1;
      end
   end

   // storage is not reset; count alone defines which entries are valid
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         if (do_pop)
            mem[top_ptr] <= push_data;
         else
            mem[top_inc] <= push_data;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: holds the fetch PC and picks the next one from
// reset / EX redirect / stall hold / ID jump / RAS prediction / increment.
//   CLK, RST                : clock, synchronous active-high reset
//   pcenable                : 1 advance, 0 stall (EX redirect still loads)
//   ex_redirect, ex_target  : EX-resolved redirect
//   id_redirect, id_target  : ID jump
//   call_push, push_addr    : push return address onto the RAS
//   ret_pop                 : pop RAS and predict its top
//   pcout                   : registered fetch PC
//   pred_valid              : 1 for the cycle after a RAS-predicted load
//   ras_empty, ras_full     : RAS status
// Build option PC_ALIGN_CHK_EN adds sticky output misalign and forces loaded
// targets to word alignment.
//
// sel        | meaning
// PCSEL_RST  | reset to RESET_PC
// PCSEL_EX   | EX redirect, overrides a stall
// PCSEL_HOLD | stall, PC and RAS frozen
// PCSEL_ID   | ID jump (may push)
// PCSEL_RAS  | return predicted from RAS top (pop, may push)
// PCSEL_INC  | sequential (may push)
module pc_sequencer
   import cpu_types_pkg::*;
#(
   parameter int                WORD_W    = 32,
   parameter logic [WORD_W-1:0] RESET_PC  = WORD_W'(PC_RESET_DEFAULT),
   parameter int                PC_INC    = PC_INC_DEFAULT,
   parameter int                RAS_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              pcenable,
   input  logic              ex_redirect,
   input  logic [WORD_W-1:0] ex_target,
   input  logic              id_redirect,
   input  logic [WORD_W-1:0] id_target,
   input  logic              call_push,
   input  logic [WORD_W-1:0] push_addr,
   input  logic              ret_pop,
   output logic [WORD_W-1:0] pcout,
   output logic              pred_valid,
   output logic              ras_empty,
`ifdef PC_ALIGN_CHK_EN
   output logic              ras_full,
   output logic              misalign
`else
   output logic              ras_full
`endif
);
   pcsel_t            sel;
   logic [WORD_W-1:0] ras_top;
   logic [WORD_W-1:0] load_tgt;
   logic [WORD_W-1:0] pc_next;
   logic              tgt_load;
   logic              ras_push;
   logic              ras_pop;

   always_comb begin
      sel = PCSEL_INC;
      if (RST)
         sel = PCSEL_RST;
      else if (ex_redirect)
         sel = PCSEL_EX;
      else if (!pcenable)
         sel = PCSEL_HOLD;
      else if (id_redirect)
         sel = PCSEL_ID;
      else if (ret_pop && !ras_empty)
         sel = PCSEL_RAS;
   end

   // ret_pop on an empty RAS falls through to INC; EX fixes the PC later
   assign ras_pop  = (sel == PCSEL_RAS);
   assign ras_push = call_push &&
                     (sel == PCSEL_ID || sel == PCSEL_RAS || sel == PCSEL_INC);
   assign tgt_load = (sel == PCSEL_EX || sel == PCSEL_ID || sel == PCSEL_RAS);

   always_comb begin
      load_tgt = '0;
      case (sel)
         PCSEL_EX:  load_tgt = ex_target;
         PCSEL_ID:  load_tgt = id_target;
         PCSEL_RAS: load_tgt = ras_top;
         default:   load_tgt = '0;
      endcase
   end

   always_comb begin
      pc_next = pcout + WORD_W'(PC_INC);
      if (sel == PCSEL_RST)
         pc_next = RESET_PC;
      else if (sel == PCSEL_HOLD)
         pc_next = pcout;
      else if (tgt_load)
`ifdef PC_ALIGN_CHK_EN
         pc_next = {load_tgt[WORD_W-1:2], 2'b00};
`else
         pc_next = load_tgt;
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pcout      <= RESET_PC;
         pred_valid <= 1'b0;
      end else begin
         pcout      <= pc_next;
         pred_valid <= (sel == PCSEL_RAS);
      end
   end

`ifdef PC_ALIGN_CHK_EN
   always_ff @(posedge CLK) begin
      if (RST)
         misalign <= 1'b0;
      else if (tgt_load && (load_tgt[1:0] != 2'b00))
         misalign <= 1'b1;
   end
`endif

   pc_ras #(
      .WORD_W (WORD_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk       (CLK),
      .rst       (RST),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (push_addr),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, then random traffic checked
// against a queue-based reference model.
module tb_pc_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   pc_seq_if #(.WORD_W(32)) bus (.clk(clk));

   pc_sequencer #(
      .WORD_W    (32),
      .RESET_PC  (32'h0),
      .PC_INC    (4),
      .RAS_DEPTH (4)
   ) dut (
      .CLK         (clk),
      .RST         (bus.rst),
      .pcenable    (bus.pcenable),
      .ex_redirect (bus.ex_redirect),
      .ex_target   (bus.ex_target),
      .id_redirect (bus.id_redirect),
      .id_target   (bus.id_target),
      .call_push   (bus.call_push),
      .push_addr   (bus.push_addr),
      .ret_pop     (bus.ret_pop),
      .pcout       (bus.pcout),
      .pred_valid  (bus.pred_valid),
      .ras_empty   (bus.ras_empty),
`ifdef PC_ALIGN_CHK_EN
      .ras_full    (bus.ras_full),
      .misalign    (bus.misalign)
`else
      .ras_full    (bus.ras_full)
`endif
   );

   typedef struct {
      logic        rst, en, ex;
      logic [31:0] ext;
      logic        id;
      logic [31:0] idt;
      logic        call;
      logic [31:0] pa;
      logic        ret;
      logic [31:0] e_pc;
      logic        e_pv, e_empty, e_full;
   } vec_t;

   vec_t vt[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model state
   logic [31:0] m_pc;
   logic        m_pv;
   logic        m_mis;
   logic [31:0] m_ras[$];

   function automatic vec_t v(logic rst, logic en, logic ex, logic [31:0] ext,
                              logic id, logic [31:0] idt, logic call, logic [31:0] pa,
                              logic ret, logic [31:0] e_pc, logic e_pv,
                              logic e_empty, logic e_full);
      vec_t r;
      r.rst = rst; r.en = en; r.ex = ex; r.ext = ext; r.id = id; r.idt = idt;
      r.call = call; r.pa = pa; r.ret = ret; r.e_pc = e_pc; r.e_pv = e_pv;
      r.e_empty = e_empty; r.e_full = e_full;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic en, input logic ex, input logic [31:0] ext,
                        input logic id, input logic [31:0] idt, input logic call,
                        input logic [31:0] pa, input logic ret);
      bus.rst = rst; bus.pcenable = en; bus.ex_redirect = ex; bus.ex_target = ext;
      bus.id_redirect = id; bus.id_target = idt; bus.call_push = call;
      bus.push_addr = pa; bus.ret_pop = ret;
   endtask

   function automatic logic [31:0] fix(logic [31:0] t);
`ifdef PC_ALIGN_CHK_EN
      return t & 32'hFFFF_FFFC;
`else
      return t;
`endif
   endfunction

   // one edge of the architectural rules, applied to the current inputs
   task automatic model_step();
      logic [31:0] tgt;
      logic        load;
      load = 1'b0;
      tgt  = '0;
      m_pv = 1'b0;
      if (bus.rst) begin
         m_pc  = 32'h0;
         m_mis = 1'b0;
         m_ras.delete();
      end else if (bus.ex_redirect) begin
         load = 1'b1; tgt = bus.ex_target;
      end else if (bus.pcenable) begin
         if (bus.id_redirect) begin
            load = 1'b1; tgt = bus.id_target;
         end else if (bus.ret_pop && m_ras.size() > 0) begin
            load = 1'b1; tgt = m_ras.pop_back(); m_pv = 1'b1;
         end else begin
            m_pc = m_pc + 32'd4;
         end
         if (bus.call_push) begin
            if (m_ras.size() == 4) void'(m_ras.pop_front());
            m_ras.push_back(bus.push_addr);
         end
      end
      if (load) begin
         m_pc = fix(tgt);
         if (tgt[1:0] != 2'b00) m_mis = 1'b1;
      end
   endtask

   logic [31:0] ext_a, idt_a;

   initial begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      m_pc = 32'h0; m_pv = 1'b0; m_mis = 1'b0;

      //      rst en ex ext           id idt        call pa         ret  pc            pv e  f
      vt.push_back(v(1, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h0,        0, 1, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h4,        0, 1, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h8,        0, 1, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'hC,        0, 1, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h10,       0, 1, 0));
      vt.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h10,       0, 1, 0));
      vt.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h10,       0, 1, 0));
      vt.push_back(v(0, 0, 1, 32'h200,      0, 32'h0,     0, 32'h0,   0, 32'h200,      0, 1, 0));
      vt.push_back(v(0, 1, 1, 32'h300,      1, 32'h400,   0, 32'h0,   0, 32'h300,      0, 1, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        1, 32'h1000,  1, 32'h24,  0, 32'h1000,     0, 0, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h1004,     0, 0, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   1, 32'h24,       1, 1, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h28,       0, 1, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     1, 32'hA0,  0, 32'h2C,       0, 0, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     1, 32'hB0,  0, 32'h30,       0, 0, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     1, 32'hC0,  0, 32'h34,       0, 0, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     1, 32'hD0,  0, 32'h38,       0, 0, 1));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     1, 32'hE0,  0, 32'h3C,       0, 0, 1));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   1, 32'hE0,       1, 0, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   1, 32'hD0,       1, 0, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   1, 32'hC0,       1, 0, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   1, 32'hB0,       1, 1, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   1, 32'hB4,       0, 1, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     1, 32'h50,  0, 32'hB8,       0, 0, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     1, 32'h60,  1, 32'h50,       1, 0, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   1, 32'h60,       1, 1, 0));
      vt.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,     1, 32'h70,  0, 32'h60,       0, 1, 0));
      vt.push_back(v(1, 0, 1, 32'h500,      0, 32'h0,     0, 32'h0,   0, 32'h0,        0, 1, 0));
      vt.push_back(v(0, 1, 1, 32'hFFFF_FFFC,0, 32'h0,     0, 32'h0,   0, 32'hFFFF_FFFC,0, 1, 0));
      vt.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h0,        0, 1, 0));
      vt.push_back(v(0, 1, 1, 32'h203,      0, 32'h0,     0, 32'h0,   0, fix(32'h203), 0, 1, 0));

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].rst, vt[i].en, vt[i].ex, vt[i].ext, vt[i].id, vt[i].idt,
               vt[i].call, vt[i].pa, vt[i].ret);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d pcout", i),      bus.pcout,             vt[i].e_pc);
         chk($sformatf("vec%0d pred_valid", i), 32'(bus.pred_valid),   32'(vt[i].e_pv));
         chk($sformatf("vec%0d ras_empty", i),  32'(bus.ras_empty),    32'(vt[i].e_empty));
         chk($sformatf("vec%0d ras_full", i),   32'(bus.ras_full),     32'(vt[i].e_full));
      end

`ifdef PC_ALIGN_CHK_EN
      chk("misalign set", 32'(bus.misalign), 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
         @(posedge clk); #1;
         chk($sformatf("misalign sticky%0d", i), 32'(bus.misalign), 32'd1);
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      chk("misalign clr", 32'(bus.misalign), 32'd0);
`endif

      // random traffic against the reference model, starting from reset
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         if (i > 0) begin
            ext_a = $urandom;
            idt_a = $urandom;
            if ($urandom_range(0, 7) != 0) ext_a[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) idt_a[1:0] = 2'b00;
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) == 0, ext_a,
                  $urandom_range(0, 7) == 0, idt_a,
                  $urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) == 0);
         end
         @(posedge clk);
         model_step();
         #1;
         chk($sformatf("rnd%0d pcout", i),      bus.pcout,           m_pc);
         chk($sformatf("rnd%0d pred_valid", i), 32'(bus.pred_valid), 32'(m_pv));
         chk($sformatf("rnd%0d ras_empty", i),  32'(bus.ras_empty),  32'(m_ras.size() == 0));
         chk($sformatf("rnd%0d ras_full", i),   32'(bus.ras_full),   32'(m_ras.size() == 4));
`ifdef PC_ALIGN_CHK_EN
         chk($sformatf("rnd%0d misalign", i),   32'(bus.misalign),   32'(m_mis));
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the pipelined core.
- Holds the fetch PC and selects the next PC each cycle from several sources:
  - sequential increment
  - ID-stage jump target
  - EX-stage branch/jump-register redirect
  - return-address-stack (RAS) prediction for returns
- Sits between the hazard unit (stall/flush) and instruction fetch. Replaces the single-source enable/next PC register.

Parameters:
- WORD_W, 32, PC and target width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, RAS entries; power of two, 2..16.

Ports:
- CLK, input, 1, core clock; all state updates on the rising edge.
- RST, input, 1, synchronous active-high reset.
- pcenable, input, 1, 1 = advance; 0 = stall (hold PC).
- ex_redirect, input, 1, EX resolved a taken branch or JR; load ex_target.
- ex_target, input, WORD_W, EX redirect address.
- id_redirect, input, 1, ID decoded J/JAL; load id_target.
- id_target, input, WORD_W, ID jump address.
- call_push, input, 1, ID decoded JAL; push push_addr onto the RAS.
- push_addr, input, WORD_W, return address (ID PC + PC_INC).
- ret_pop, input, 1, ID decoded JR $31; pop the RAS and predict its top.
- pcout, output, WORD_W, current fetch PC.
- pred_valid, output, 1, pulses 1 cycle when the PC was loaded from a RAS prediction.
- ras_empty, output, 1, RAS count == 0.
- ras_full, output, 1, RAS count == RAS_DEPTH.

Behaviour:

Reset:
- Synchronous; RST sampled at the edge has highest priority.
- pcout = RESET_PC, pred_valid = 0, RAS count = 0, ras_empty = 1, ras_full = 0.
- A reset during a stall or a redirect wins outright.

Next-PC priority each edge, highest first:
1. RST.
2. ex_redirect: pcout <= ex_target. Applies even when pcenable = 0, because a flush overrides a stall. RAS is untouched.
3. pcenable = 0: hold pcout. No RAS push or pop.
4. id_redirect: pcout <= id_target. If call_push is also 1, push in the same cycle.
5. ret_pop with RAS non-empty: pcout <= RAS top, pop, pred_valid <= 1 for one cycle.
6. ret_pop with RAS empty: no prediction. pcout <= pcout + PC_INC; EX supplies the real target later via ex_redirect.
7. Otherwise: pcout <= pcout + PC_INC.

Arithmetic:
- Increment is modulo 2^WORD_W; 32'hFFFF_FFFC + 4 = 32'h0.

Latency:
- Redirects take effect on pcout one cycle after they are sampled; there is no combinational path from inputs to pcout.

RAS:
- Circular buffer with top pointer and count.
- Push when full: overwrite the oldest entry and advance the pointer; count stays at RAS_DEPTH.
- Pop when empty: ignored.
- call_push and ret_pop together: pop first, then push. Net count is unchanged and the top is replaced.
- call_push without id_redirect is legal; the push happens and the PC follows the normal priority.

pred_valid:
- Registered; 0 on every cycle that was not case 5.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- With the macro defined:
  - Adds output misalign, 1 bit, sticky.
  - Any loaded target (ex_target, id_target, RAS top) with bits [1:0] != 0 sets misalign.
  - The PC is loaded with bits [1:0] forced to 0.
  - misalign clears only on RST.
- Without the macro: no misalign port; targets are loaded unmodified.

Decomposition:
- cpu_types_pkg supplies word_t.
- Add to cpu_types_pkg: PC_RESET_DEFAULT and PC_INC_DEFAULT constants, and pcsel_t, an enum {PCSEL_RST, PCSEL_EX, PCSEL_HOLD, PCSEL_ID, PCSEL_RAS, PCSEL_INC} used for the priority mux.
- Add pc_seq_if interface with modports pcseq and tb.
- One natural sub-module: pc_ras, the circular stack with push/pop/top/empty/full, parametrised by RAS_DEPTH and WORD_W.

Test Plan:
1. Reset and sequential fetch: RST = 1 for 1 cycle, then pcenable = 1 for 3 cycles -> pcout = 0x0, 0x4, 0x8, 0xC; ras_empty = 1.
2. Stall vs flush: at pcout = 0x10, drive pcenable = 0 for 2 cycles -> pcout holds 0x10. Then pcenable = 0 with ex_redirect = 1, ex_target = 0x200 -> pcout = 0x200 on the next cycle.
3. Priority: ex_redirect (0x300) and id_redirect (0x400) in the same cycle -> pcout = 0x300; RAS unchanged.
4. Call/return: id_redirect = 1, id_target = 0x1000, call_push = 1, push_addr = 0x24 -> pcout = 0x1000. Later ret_pop = 1 -> pcout = 0x24, pred_valid = 1 for one cycle, ras_empty = 1.
5. RAS overflow/underflow with RAS_DEPTH = 4: push A, B, C, D, E -> ras_full = 1. Five pops predict E, D, C, B, then the fifth gets no prediction (pcout + 4, pred_valid = 0).
6. Wrap, plus PC_ALIGN_CHK_EN build: pcout = 0xFFFF_FFFC, increment -> 0x0. ex_target = 0x203 -> pcout = 0x200, misalign = 1 and stays 1 until RST.
